// File: rtl/chacha_block_core.sv
// ChaCha block function: loads key/nonce/counter, runs the rounds on QR_PER_CYCLE
// parallel quarter-round units, adds the input state back and hands out 512 bits.
module chacha_block_core #(
  parameter int NUM_ROUNDS   = 20,
  parameter int QR_PER_CYCLE = 4,
  parameter int BLK_CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [255:0]         key,
  input  logic [95:0]          nonce,
  input  logic [31:0]          ctr_in,
  input  logic                 cont_en,
  input  logic                 abort,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [511:0]         out_block,
  output logic [31:0]          out_ctr,
  output logic                 ctr_wrap,
  output logic                 busy,
  output logic [BLK_CNT_W-1:0] blocks_done
);

  localparam int N      = NUM_ROUNDS * 4 / QR_PER_CYCLE;
  localparam int STEP_W = $clog2(N);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(N - 1);
  localparam logic [2:0]        QR_INC    = 3'(QR_PER_CYCLE);

  if (!(NUM_ROUNDS == 8 || NUM_ROUNDS == 12 || NUM_ROUNDS == 20)) begin : g_bad_rounds
    $error("chacha_block_core: NUM_ROUNDS must be 8, 12 or 20");
  end
  if (!(QR_PER_CYCLE == 1 || QR_PER_CYCLE == 2 || QR_PER_CYCLE == 4)) begin : g_bad_qr
    $error("chacha_block_core: QR_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_OUT} state_t;

  state_t              state;
  logic [511:0]        work;
  logic [511:0]        saved;
  logic [511:0]        init;
  logic [511:0]        round_nxt;
  logic [511:0]        sum;
  logic [STEP_W-1:0]   step;
  logic [2:0]          qr_base;
  logic                cont_lat;
  logic [15:0]         qi;
  logic [127:0]        qv;

  function automatic logic [127:0] quarter_round(input logic [31:0] a_in, input logic [31:0] b_in,
                                                 input logic [31:0] c_in, input logic [31:0] d_in);
    logic [31:0] a, b, c, d;
    a = a_in; b = b_in; c = c_in; d = d_in;
    a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
    c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
    a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
    c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
    return {a, b, c, d};
  endfunction

  // Word indices {row,col} of quarter-round q: 0-3 columns, 4-7 diagonals.
  function automatic logic [15:0] qr_index(input logic [2:0] q);
    logic [1:0] j;
    j = q[1:0];
    if (!q[2]) return {2'd0, j, 2'd1, j, 2'd2, j, 2'd3, j};
    return {2'd0, j, 2'd1, j + 2'd1, 2'd2, j + 2'd2, 2'd3, j + 2'd3};
  endfunction

  assign init = {nonce, ctr_in, key,
                 32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};

  // Quarter-rounds issued together never share a word, so they chain freely here.
  always_comb begin
    round_nxt = work;
    qi        = '0;
    qv        = '0;
    for (int k = 0; k < QR_PER_CYCLE; k++) begin
      qi = qr_index(qr_base + 3'(k));
      qv = quarter_round(round_nxt[{qi[15:12], 5'd0} +: 32], round_nxt[{qi[11:8], 5'd0} +: 32],
                         round_nxt[{qi[7:4], 5'd0} +: 32],   round_nxt[{qi[3:0], 5'd0} +: 32]);
      round_nxt[{qi[15:12], 5'd0} +: 32] = qv[127:96];
      round_nxt[{qi[11:8], 5'd0} +: 32]  = qv[95:64];
      round_nxt[{qi[7:4], 5'd0} +: 32]   = qv[63:32];
      round_nxt[{qi[3:0], 5'd0} +: 32]   = qv[31:0];
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < 16; i++) sum[32*i +: 32] = work[32*i +: 32] + saved[32*i +: 32];
  end

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_OUT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      work        <= '0;
      saved       <= '0;
      step        <= '0;
      qr_base     <= '0;
      cont_lat    <= 1'b0;
      out_block   <= '0;
      out_ctr     <= '0;
      ctr_wrap    <= 1'b0;
      blocks_done <= '0;
    end else begin
      ctr_wrap <= 1'b0;
      if (state != S_IDLE && abort) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: if (in_valid) begin
            work     <= init;
            saved    <= init;
            cont_lat <= cont_en;
            step     <= '0;
            qr_base  <= '0;
            state    <= S_ROUND;
          end
          S_ROUND: begin
            work    <= round_nxt;
            step    <= step + 1'b1;
            qr_base <= qr_base + QR_INC;
            if (step == STEP_LAST) state <= S_FINAL;
          end
          S_FINAL: begin
            out_block <= sum;
            out_ctr   <= saved[415:384];
            state     <= S_OUT;
          end
          S_OUT: if (out_ready) begin
            blocks_done <= blocks_done + 1'b1;
            cont_lat    <= cont_en;
            if (cont_lat && cont_en) begin
              if (out_ctr == 32'hFFFF_FFFF) begin
                ctr_wrap <= 1'b1;
                state    <= S_IDLE;
              end else begin
                work    <= {saved[511:416], out_ctr + 32'd1, saved[383:0]};
                saved   <= {saved[511:416], out_ctr + 32'd1, saved[383:0]};
                step    <= '0;
                qr_base <= '0;
                state   <= S_ROUND;
              end
            end else begin
              state <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
